// File: rtl/shift_arbiter_if.sv
// Request/grant/result bundle between two shift requesters and shift_arbiter.
// The arbiter connects through the slave modport and requesters through the master modport.
interface shift_arbiter_if;
  logic        req0;
  logic [15:0] in0;
  logic [1:0]  op0;
  logic [3:0]  cnt0;
  logic        req1;
  logic [15:0] in1;
  logic [1:0]  op1;
  logic [3:0]  cnt1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] out;
  logic        busy;

  modport slave (
    input  req0, in0, op0, cnt0, req1, in1, op1, cnt1,
    output gnt0, gnt1, done0, done1, out, busy
  );

  modport master (
    output req0, in0, op0, cnt0, req1, in1, op1, cnt1,
    input  gnt0, gnt1, done0, done1, out, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 16-bit rotate/shift unit.
// Each operation takes three cycles: grant (IDLE), compute (EXEC), report (DONE).
module shift_arbiter (
  input  logic             clk,
  input  logic             rst,
  shift_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [15:0] opnd_q, opnd_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic        pick;
  logic        gnt0, gnt1, done0, done1;

  logic [31:0] dbl;
  logic [31:0] rot;
  logic [3:0]  amt;
  logic [15:0] res;

  // Rotate left by k is rotate right by (16-k) mod 16, so both rotates share one path.
  always_comb begin
    dbl = {opnd_q, opnd_q};
    amt = (op_q == 2'b10) ? (4'd0 - cnt_q) : cnt_q;
    rot = dbl >> amt;
    res = rot[15:0];
    case (op_q)
      2'b01:   res = opnd_q >> cnt_q;
      2'b11:   res = opnd_q << cnt_q;
      default: res = rot[15:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pick    = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    case (state_q)
      StIdle: begin
        // Outputs are gated by rst so no pulse appears while reset is held.
        if (!rst && (bus.req0 || bus.req1)) begin
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          owner_d = pick;
          last_d  = pick;
          gnt0    = ~pick;
          gnt1    = pick;
          opnd_d  = pick ? bus.in1  : bus.in0;
          op_d    = pick ? bus.op1  : bus.op0;
          cnt_d   = pick ? bus.cnt1 : bus.cnt0;
          state_d = StExec;
        end
      end
      StExec: begin
        out_d   = res;
        state_d = StDone;
      end
      StDone: begin
        if (!rst) begin
          done0 = ~owner_q;
          done1 = owner_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      opnd_q  <= 16'h0000;
      op_q    <= 2'b00;
      cnt_q   <= 4'd0;
      out_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.done0 = done0;
  assign bus.done1 = done1;
  assign bus.out   = out_q;
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: per-scenario tasks with hand-computed expectations.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        who;
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic who, input logic val, input logic [15:0] in,
                           input logic [1:0] op, input logic [3:0] cnt);
    if (who) begin
      bus.req1 = val; bus.in1 = in; bus.op1 = op; bus.cnt1 = cnt;
    end else begin
      bus.req0 = val; bus.in0 = in; bus.op0 = op; bus.cnt0 = cnt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(1'b0, 1'b1, 16'hFFFF, 2'b00, 4'd0);
    drive_req(1'b1, 1'b0, 16'h0000, 2'b00, 4'd0);
    next_cycle();
    next_cycle();
    sample();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.out !== 16'h0000) begin
      errors++; $display("FAIL reset_out got %h want 0000", bus.out);
    end
    checks++;
    if ({bus.gnt1, bus.gnt0, bus.done1, bus.done0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses got %b want 0000", {bus.gnt1, bus.gnt0, bus.done1, bus.done0});
    end
    next_cycle();
    rst = 1'b0;
    bus.req0 = 1'b0;
    sample();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_ops();
    vec_t v [13];
    v[0]  = '{1'b0, 16'h8001, 2'b00, 4'd1,  16'hC000};
    v[1]  = '{1'b1, 16'h8001, 2'b01, 4'd4,  16'h0800};
    v[2]  = '{1'b1, 16'h8001, 2'b10, 4'd1,  16'h0003};
    v[3]  = '{1'b1, 16'h8001, 2'b11, 4'd15, 16'h8000};
    v[4]  = '{1'b0, 16'hA5C3, 2'b00, 4'd0,  16'hA5C3};
    v[5]  = '{1'b0, 16'hA5C3, 2'b01, 4'd0,  16'hA5C3};
    v[6]  = '{1'b1, 16'hA5C3, 2'b10, 4'd0,  16'hA5C3};
    v[7]  = '{1'b1, 16'hA5C3, 2'b11, 4'd0,  16'hA5C3};
    v[8]  = '{1'b0, 16'h1234, 2'b10, 4'd4,  16'h2341};
    v[9]  = '{1'b0, 16'h1234, 2'b00, 4'd4,  16'h4123};
    v[10] = '{1'b1, 16'h1234, 2'b11, 4'd4,  16'h2340};
    v[11] = '{1'b0, 16'h8000, 2'b01, 4'd15, 16'h0001};
    v[12] = '{1'b1, 16'h0001, 2'b10, 4'd15, 16'h8000};
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      drive_req(v[i].who, 1'b1, v[i].in, v[i].op, v[i].cnt);
      sample();
      checks++;
      if ({bus.gnt1, bus.gnt0} !== (v[i].who ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL op%0d_gnt got %b want %b", i, {bus.gnt1, bus.gnt0},
                           (v[i].who ? 2'b10 : 2'b01));
      end
      next_cycle();
      sample();
      checks++;
      if ({bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0} !== 5'b10000) begin
        errors++; $display("FAIL op%0d_exec got %b want 10000", i,
                           {bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0});
      end
      next_cycle();
      sample();
      checks++;
      if ({bus.done1, bus.done0} !== (v[i].who ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL op%0d_done got %b want %b", i, {bus.done1, bus.done0},
                           (v[i].who ? 2'b10 : 2'b01));
      end
      checks++;
      if (bus.out !== v[i].exp) begin
        errors++; $display("FAIL op%0d_out got %h want %h", i, bus.out, v[i].exp);
      end
      drive_req(v[i].who, 1'b0, 16'h0000, 2'b00, 4'd0);
      next_cycle();
      sample();
      checks++;
      if ({bus.busy, bus.done1, bus.done0} !== 3'b000 || bus.out !== v[i].exp) begin
        errors++; $display("FAIL op%0d_idle_hold got busy/done %b out %h want 000 %h", i,
                           {bus.busy, bus.done1, bus.done0}, bus.out, v[i].exp);
      end
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    drive_req(1'b0, 1'b1, 16'h1234, 2'b00, 4'd0);
    drive_req(1'b1, 1'b1, 16'h00F0, 2'b01, 4'd4);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      sample();
      checks++;
      if ({bus.gnt1, bus.gnt0} !== {(c % 6) == 3, (c % 6) == 0}) begin
        errors++; $display("FAIL rr_gnt_c%0d got %b want %b", c, {bus.gnt1, bus.gnt0},
                           {(c % 6) == 3, (c % 6) == 0});
      end
      checks++;
      if ({bus.done1, bus.done0} !== {(c % 6) == 5, (c % 6) == 2}) begin
        errors++; $display("FAIL rr_done_c%0d got %b want %b", c, {bus.done1, bus.done0},
                           {(c % 6) == 5, (c % 6) == 2});
      end
      if ((c % 6) == 2) begin
        checks++;
        if (bus.out !== 16'h1234) begin
          errors++; $display("FAIL rr_out0_c%0d got %h want 1234", c, bus.out);
        end
      end
      if ((c % 6) == 5) begin
        checks++;
        if (bus.out !== 16'h000F) begin
          errors++; $display("FAIL rr_out1_c%0d got %h want 000f", c, bus.out);
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_in_exec();
    next_cycle();
    drive_req(1'b0, 1'b1, 16'h00FF, 2'b01, 4'd0);
    sample();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++; $display("FAIL rexec_gnt got %b want 1", bus.gnt0);
    end
    next_cycle();
    rst = 1'b1;
    bus.req0 = 1'b0;
    sample();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rexec_busy_in_exec got %b want 1", bus.busy);
    end
    next_cycle();
    rst = 1'b0;
    drive_req(1'b0, 1'b1, 16'h0F0F, 2'b11, 4'd4);
    sample();
    checks++;
    if ({bus.busy, bus.done1, bus.done0} !== 3'b000 || bus.out !== 16'h0000) begin
      errors++; $display("FAIL rexec_abort got busy/done %b out %h want 000 0000",
                         {bus.busy, bus.done1, bus.done0}, bus.out);
    end
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++; $display("FAIL rexec_regrant got %b want 1", bus.gnt0);
    end
    next_cycle();
    next_cycle();
    sample();
    checks++;
    if (bus.done0 !== 1'b1 || bus.out !== 16'hF0F0) begin
      errors++; $display("FAIL rexec_result got done %b out %h want 1 f0f0", bus.done0, bus.out);
    end
    bus.req0 = 1'b0;
    next_cycle();
  endtask

  task automatic test_operand_hold();
    next_cycle();
    drive_req(1'b0, 1'b1, 16'h00FF, 2'b01, 4'd8);
    sample();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++; $display("FAIL hold_gnt got %b want 1", bus.gnt0);
    end
    next_cycle();
    drive_req(1'b0, 1'b1, 16'hFFFF, 2'b11, 4'd0);
    next_cycle();
    sample();
    checks++;
    if (bus.done0 !== 1'b1 || bus.out !== 16'h0000) begin
      errors++; $display("FAIL hold_out got done %b out %h want 1 0000", bus.done0, bus.out);
    end
    bus.req0 = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive_req(1'b0, 1'b1, 16'h0001, 2'b00, 4'd1);
    next_cycle();
    next_cycle();
    drive_req(1'b1, 1'b1, 16'h0001, 2'b10, 4'd15);
    sample();
    checks++;
    if ({bus.gnt1, bus.done0} !== 2'b01 || bus.out !== 16'h8000) begin
      errors++; $display("FAIL b2b_done_cycle got gnt1/done0 %b out %h want 01 8000",
                         {bus.gnt1, bus.done0}, bus.out);
    end
    bus.req0 = 1'b0;
    next_cycle();
    sample();
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
      errors++; $display("FAIL b2b_gnt1 got %b want 10", {bus.gnt1, bus.gnt0});
    end
    next_cycle();
    next_cycle();
    sample();
    checks++;
    if ({bus.done1, bus.done0} !== 2'b10 || bus.out !== 16'h8000) begin
      errors++; $display("FAIL b2b_done1 got %b out %h want 10 8000",
                         {bus.done1, bus.done0}, bus.out);
    end
    bus.req1 = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.in0 = '0; bus.op0 = '0; bus.cnt0 = '0;
    bus.req1 = 1'b0; bus.in1 = '0; bus.op1 = '0; bus.cnt1 = '0;
    test_reset();
    test_ops();
    test_round_robin();
    test_reset_in_exec();
    test_operand_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
